// File: rtl/aes_core_arbiter.sv
// -----------------------------------------------------------------------------
// aes_core_arbiter
//
// Purpose:
//   Shares a single AES_top encryption core among NUM_REQ requesters using
//   round-robin arbitration. The winner's plaintext and key are captured, the
//   core enable is held until the core reports valid, and the ciphertext is
//   returned with the requester index over a valid/ready response port.
//   Only one transaction is in flight at a time.
//
// Optional feature (compile-time macro AES_ARB_TIMEOUT_EN):
//   When defined, a watchdog counts BUSY cycles. After TIMEOUT_CYCLES cycles
//   without a core valid, the transaction completes with rsp_err=1 and
//   rsp_data=0. When undefined, no counter is built, rsp_err is tied to 0 and
//   BUSY waits indefinitely.
//
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   ID_W           width of rsp_id, 2**ID_W >= NUM_REQ
//   TIMEOUT_CYCLES watchdog limit in cycles (only with AES_ARB_TIMEOUT_EN)
//
// Ports:
//   AES_clk             in   clock, rising edge
//   AES_rst             in   asynchronous reset, active-high
//   req_valid           in   per-requester request valid
//   req_ready           out  per-requester accept, one-hot or zero
//   req_data            in   plaintexts, requester i at [i*128 +: 128]
//   req_key             in   keys, same packing as req_data
//   rsp_valid           out  response valid
//   rsp_ready           in   response accept
//   rsp_data            out  ciphertext (0 on timeout)
//   rsp_id              out  index of the served requester
//   rsp_err             out  1 = timed-out transaction
//   core_en             out  to AES_en
//   core_data_in        out  to AES_data_in
//   core_key_in         out  to AES_key_in
//   core_data_out       in   from AES_data_out
//   core_data_out_valid in   from AES_data_out_valid
// -----------------------------------------------------------------------------
module aes_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_err,
  output logic                   core_en,
  output logic [127:0]           core_data_in,
  output logic [127:0]           core_key_in,
  input  logic [127:0]           core_data_out,
  input  logic                   core_data_out_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESP
  } state_t;

  state_t state, state_next;

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      ptr_next;
  logic [ID_W-1:0]      id_reg;
  logic                 grant_found;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  int                   grant_off;
  int                   grant_int;
  int                   next_int;
  logic [127:0]         data_reg;
  logic [127:0]         key_reg;
  logic [127:0]         sel_data;
  logic [127:0]         sel_key;
  logic                 accept;
  logic                 finish_ok;
  logic                 finish_to;
  logic                 handshake;
  logic                 timeout_hit;

  // Reject parameter combinations the id field cannot represent.
  if ((2**ID_W < NUM_REQ) || (NUM_REQ < 2) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("aes_core_arbiter: illegal parameter combination");
  end

  // Rotate the request vector so that bit 0 corresponds to rr_ptr; the lowest
  // set bit of the rotated vector is then the round-robin winner.
  assign dbl_valid = {req_valid, req_valid} >> rr_ptr;
  assign rot_valid = dbl_valid[NUM_REQ-1:0];

  always_comb begin
    grant_found = 1'b0;
    grant_off   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_found = 1'b1;
        grant_off   = k;
      end
    end
    grant_int = int'(rr_ptr) + grant_off;
    if (grant_int >= NUM_REQ) grant_int = grant_int - NUM_REQ;
    grant_idx = ID_W'(grant_int);
    next_int  = grant_int + 1;
    if (next_int >= NUM_REQ) next_int = 0;
    ptr_next = ID_W'(next_int);
  end

  // Pick the winner's plaintext and key out of the packed request buses.
  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_data = req_data[i*128 +: 128];
        sel_key  = req_key[i*128 +: 128];
      end
    end
  end

  // req_ready depends only on state and req_valid, never on rsp_ready, and is
  // forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == IDLE) && !AES_rst && grant_found && (grant_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             rsp_err_q;

  // Watchdog counter: cleared in LAUNCH, counts every BUSY cycle.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      to_cnt <= '0;
    end else if (state == LAUNCH) begin
      to_cnt <= '0;
    end else if (state == BUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // The limit fires on the BUSY cycle where the count is about to reach
  // TIMEOUT_CYCLES; a core valid in that same cycle takes priority.
  assign timeout_hit = (state == BUSY) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err     = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the one-cycle strobes that drive the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          accept     = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        state_next = BUSY;
      end
      BUSY: begin
        if (core_data_out_valid) begin
          finish_ok  = 1'b1;
          state_next = RESP;
        end else if (timeout_hit) begin
          finish_to  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: request capture, core enable and response holding.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      rr_ptr    <= '0;
      id_reg    <= '0;
      data_reg  <= '0;
      key_reg   <= '0;
      core_en   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        data_reg <= sel_data;
        key_reg  <= sel_key;
        id_reg   <= grant_idx;
        rr_ptr   <= ptr_next;
      end
      if (state == LAUNCH) begin
        core_en <= 1'b1;
      end
      if (finish_ok) begin
        core_en   <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_data  <= core_data_out;
        rsp_id    <= id_reg;
`ifdef AES_ARB_TIMEOUT_EN
        rsp_err_q <= 1'b0;
`endif
      end
      if (finish_to) begin
        core_en   <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_data  <= '0;
        rsp_id    <= id_reg;
`ifdef AES_ARB_TIMEOUT_EN
        rsp_err_q <= 1'b1;
`endif
      end
      if (handshake) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Core inputs come straight from the capture registers, so they stay
  // stable for the whole LAUNCH/BUSY window.
  assign core_data_in = data_reg;
  assign core_key_in  = key_reg;

endmodule
